arbiter_5_req_ctrl: RTL and testbench
=====================================

# arbiter_5_req_ctrl

Synchronous request/grant controller wrapped around the 5-way mutex arbiter. It turns five clocked client request levels into the arbiter's asynchronous X4..X0 inputs and synchronises the arbiter's Y4..Y0 outputs back into the clock domain. It returns a registered one-hot grant to each client under a 4-phase handshake with the arbiter. It sits directly upstream and downstream of the arbiter, between the clients and the mutex network.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the `arb_y` synchroniser. Legal values are ≥2.
- `HOLD_MAX`, default 255: 16-bit maximum grant-hold cycle count. 0 disables the timeout.

- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  5  client request levels, synchronous to `clk`. Bit i is client i.
- `done`  in  5  one-cycle release pulse from client i.
- `grant`  out  5  registered grant to clients. At most one bit is set.
- `arb_x`  out  5  registered drive to arbiter X4..X0 (bit i → Xi).
- `arb_y`  in  5  arbiter Y4..Y0. Asynchronous to `clk`.
- `timeout`  out  1  one-cycle pulse when a grant is force-released.
- `err_multi`  out  1  sticky flag: more than one synchronised `arb_y` bit was seen high.

## Operation
- Each `arb_y` bit passes through its own `SYNC_STAGES`-deep synchroniser. The output is `ys[i]`.
- Each client has an independent 4-state FSM: IDLE, REQ, GRANT, REL.
- IDLE (`arb_x[i]`=0, `grant[i]`=0):
  - → REQ when `req[i]`=1 and `ys[i]`=0.
  - If `ys[i]`=1 (stale arbiter output), it stays in IDLE.
- REQ (`arb_x[i]`=1, `grant[i]`=0):
  - → GRANT when `ys[i]`=1.
  - → REL when `req[i]`=0 (request withdrawn before win).
- GRANT (`arb_x[i]`=1, `grant[i]`=1):
  - → REL on `done[i]`=1, on `req[i]`=0, or on hold-counter expiry.
- REL (`arb_x[i]`=0, `grant[i]`=0):
  - → IDLE when `ys[i]`=0. This is the return-to-zero phase; no re-request is made before the arbiter has released.
- `done[i]` outside GRANT is ignored.
- Hold counter: a single shared 16-bit counter, since at most one client holds a grant.
  - Clears whenever no FSM is in GRANT.
  - Increments each cycle any FSM is in GRANT.
  - If `HOLD_MAX`≠0 and the counter reaches `HOLD_MAX` while in GRANT without `done` or a `req` drop, the holder goes to REL and `timeout` pulses for that cycle.
  - `done` in the same cycle as expiry takes priority: normal release, no `timeout`.
- `err_multi` sets on any cycle where the population count of `ys` exceeds 1. Only `rst_n` clears it.
- `grant` is derived only from FSM state, never combinationally from `arb_y`.

## Timing
- Reset (async assert, synchronous-safe deassert):
  - All FSMs go to IDLE and all synchroniser flops to 0.
  - `arb_x`=0, `grant`=0, `timeout`=0, `err_multi`=0, counter=0.
- Request to grant:
  - `req[i]` is sampled high at edge n, so `arb_x[i]`=1 after n.
  - With immediate arbiter resolution, `ys[i]` is high after edge n+`SYNC_STAGES`, and `grant[i]`=1 after edge n+`SYNC_STAGES`+1.
  - With default parameters this is 3 cycles.
- Release:
  - `done[i]` is sampled at edge m, so `grant[i]`=0 and `arb_x[i]`=0 after m.
  - IDLE is reached after m+`SYNC_STAGES`+1.
  - The earliest re-assertion of `arb_x[i]` is after m+`SYNC_STAGES`+2.
- Contention: a loser stays in REQ with `arb_x` high. It obtains its grant `SYNC_STAGES`+1 cycles after the arbiter hands over.
- `timeout` is high for exactly the cycle after the expiry edge, coincident with `grant` falling.
- Reset mid-GRANT: `arb_x` drops immediately. A client requesting after reset waits in IDLE until `ys[i]`=0.

## Test plan
- Single request: `req`=5'b00100 at cycle 10, with the arbiter model returning Y=X after 2 ns. Required: `arb_x`=00100 after cycle 10, `grant`=00100 after cycle 13; `done[2]` pulse at cycle 20 → `grant`=0 after 20, IDLE after 23.
- Contention: `req`=11111 in the same cycle, with the model granting X4 first. Required: `grant` sequences 10000, 01000, 00100, 00010, 00001 with each client pulsing `done` 5 cycles after its grant; `grant` is never multi-hot and `err_multi` stays 0.
- Withdraw: `req[1]` rises and then falls after 1 cycle while client 3 holds the grant. Required: `arb_x[1]` returns to 0, no `grant[1]`, and client 1 returns to IDLE.
- Timeout: `HOLD_MAX`=8 and client 0 granted with no `done`. Required: `grant[0]` falls and `timeout`=1 on the same cycle, 8 cycles after grant; with `HOLD_MAX`=0 the grant persists for 1000 cycles.
- Reset mid-grant: `rst_n` low for 2 cycles while `grant`=00010. Required: all outputs are 0 asynchronously, and the re-request is granted only after `ys[1]` has been observed low.
- Fault injection: force `arb_y`=00011. Required: `err_multi`=1 after `SYNC_STAGES`+1 edges and it remains set until reset.

Source files
------------

// File: rtl/arbiter_5_req_ctrl.sv
// Clocked request/grant front end for the 5-way mutex arbiter: drives X4..X0,
// synchronises Y4..Y0 and runs a 4-phase handshake per client.
module arbiter_5_req_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [15:0] HOLD_MAX    = 16'd255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] req,
   input  logic [4:0] done,
   output logic [4:0] grant,
   output logic [4:0] arb_x,
   input  logic [4:0] arb_y,
   output logic       timeout,
   output logic       err_multi
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_GRANT,
      ST_REL
   } state_e;

   state_e                         state_q [5];
   state_e                         state_d [5];
   logic [SYNC_STAGES-1:0][4:0]    sync_q;
   logic [SYNC_STAGES-1:0][4:0]    sync_d;
   logic [15:0]                    hold_q;
   logic [15:0]                    hold_d;
   logic [4:0]                     grant_q;
   logic [4:0]                     grant_d;
   logic [4:0]                     arb_x_q;
   logic [4:0]                     arb_x_d;
   logic                           timeout_q;
   logic                           timeout_d;
   logic                           err_q;
   logic                           err_d;
   logic [4:0]                     ys;
   logic                           any_grant;
   logic                           expire;

   assign ys = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], arb_y};
      any_grant = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (state_q[i] == ST_GRANT) any_grant = 1'b1;
      end
      // Compare against the post-increment count so the holder gets exactly HOLD_MAX cycles.
      expire    = (HOLD_MAX != '0) && any_grant &&
                  (({1'b0, hold_q} + 17'd1) == {1'b0, HOLD_MAX});
      hold_d    = any_grant ? hold_q + 16'd1 : '0;
      err_d     = err_q | ($countones(ys) > 1);
      timeout_d = 1'b0;
      grant_d   = '0;
      arb_x_d   = '0;

      for (int unsigned i = 0; i < 5; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (req[i] && !ys[i]) state_d[i] = ST_REQ;
            end
            ST_REQ: begin
               if (ys[i])       state_d[i] = ST_GRANT;
               else if (!req[i]) state_d[i] = ST_REL;
            end
            ST_GRANT: begin
               if (done[i] || !req[i]) begin
                  state_d[i] = ST_REL;
               end else if (expire) begin
                  state_d[i] = ST_REL;
                  timeout_d  = 1'b1;
               end
            end
            ST_REL: begin
               if (!ys[i]) state_d[i] = ST_IDLE;
            end
            default: state_d[i] = ST_IDLE;
         endcase
         arb_x_d[i] = (state_d[i] == ST_REQ) || (state_d[i] == ST_GRANT);
         grant_d[i] = (state_d[i] == ST_GRANT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 5; i++) state_q[i] <= ST_IDLE;
         sync_q    <= '0;
         hold_q    <= '0;
         grant_q   <= '0;
         arb_x_q   <= '0;
         timeout_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < 5; i++) state_q[i] <= state_d[i];
         sync_q    <= sync_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
         arb_x_q   <= arb_x_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
      end
   end

   assign grant     = grant_q;
   assign arb_x     = arb_x_q;
   assign timeout   = timeout_q;
   assign err_multi = err_q;

endmodule

// File: tb/tb_arbiter_5_req_ctrl.sv
// Randomised bench for arbiter_5_req_ctrl with a behavioural mutex and a
// per-client handshake reference model.
module tb_arbiter_5_req_ctrl;

   localparam int SS   = 2;
   localparam int HOLD = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] req = '0;
   logic [4:0] done = '0;
   logic [4:0] grant;
   logic [4:0] arb_x;
   logic [4:0] arb_y;
   logic       timeout;
   logic       err_multi;

   logic [4:0] req_b = '0;
   logic [4:0] done_b = '0;
   logic [4:0] grant_b;
   logic [4:0] arb_x_b;
   logic [4:0] arb_y_b = '0;
   logic       timeout_b;
   logic       err_b;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   arbiter_5_req_ctrl #(.SYNC_STAGES(SS), .HOLD_MAX(16'(HOLD))) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .done(done), .grant(grant),
      .arb_x(arb_x), .arb_y(arb_y), .timeout(timeout), .err_multi(err_multi)
   );

   arbiter_5_req_ctrl #(.SYNC_STAGES(SS), .HOLD_MAX(16'd0)) u_dut_nohold (
      .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b), .grant(grant_b),
      .arb_x(arb_x_b), .arb_y(arb_y_b), .timeout(timeout_b), .err_multi(err_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural mutex: the holder keeps Y while its X stays high, otherwise the
   // highest-numbered pending X wins; outputs settle 2 time units after X moves.
   logic [4:0] y_arb = '0;
   logic       fault_en = 1'b0;
   logic [4:0] fault_val = '0;
   assign arb_y = fault_en ? fault_val : y_arb;

   function automatic logic [4:0] mutex(input logic [4:0] x, input logic [4:0] cur);
      logic [4:0] r;
      r = '0;
      if ((cur & x) != '0) return cur & x;
      for (int i = 4; i >= 0; i--) begin
         if (x[i] && r == '0) r[i] = 1'b1;
      end
      return r;
   endfunction

   always begin
      @(arb_x);
      #2;
      y_arb = mutex(arb_x, y_arb);
   end

   always begin
      @(arb_x_b);
      #2;
      arb_y_b = arb_x_b;
   end

   // Reference model: x_m = client is asserting X, g_m = client owns the grant,
   // rel_m = client dropped X and waits for its Y to clear.
   logic [4:0] hist [SS];
   logic [4:0] ys_m, g_m, x_m, rel_m, g_n, x_n, r_n;
   logic       to_m, err_m;
   int         held;
   bit         owner, expire;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_m = '0; x_m = '0; rel_m = '0; to_m = 1'b0; err_m = 1'b0; held = 0;
         for (int j = 0; j < SS; j++) hist[j] = '0;
      end else begin
         ys_m   = hist[SS-1];
         owner  = (g_m != '0);
         expire = owner && (HOLD != 0) && (held + 1 == HOLD);
         held   = owner ? held + 1 : 0;
         err_m  = err_m | ($countones(ys_m) > 1);
         to_m   = 1'b0;
         g_n = g_m; x_n = x_m; r_n = rel_m;
         for (int i = 0; i < 5; i++) begin
            if (g_m[i]) begin
               if (done[i] || !req[i] || expire) begin
                  g_n[i] = 1'b0; x_n[i] = 1'b0; r_n[i] = 1'b1;
                  if (!done[i] && req[i]) to_m = 1'b1;
               end
            end else if (x_m[i]) begin
               if (ys_m[i]) g_n[i] = 1'b1;
               else if (!req[i]) begin x_n[i] = 1'b0; r_n[i] = 1'b1; end
            end else if (rel_m[i]) begin
               if (!ys_m[i]) r_n[i] = 1'b0;
            end else if (req[i] && !ys_m[i]) begin
               x_n[i] = 1'b1;
            end
         end
         g_m = g_n; x_m = x_n; rel_m = r_n;
         for (int j = SS - 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = arb_y;
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("grant", grant, g_m);
         check("arb_x", arb_x, x_m);
         check("timeout", timeout, to_m);
         check("err_multi", err_multi, err_m);
         check("onehot", ($countones(grant) <= 1), 1);
      end
   end

   task automatic wait_grant(input logic [4:0] mask, input string tag);
      int n;
      n = 0;
      while ((grant & mask) == '0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, ((grant & mask) != '0), 1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int drops;
      bit saw_g1;
      logic [4:0] exp;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", grant, 0);
      check("rst_arb_x", arb_x, 0);
      check("rst_timeout", timeout, 0);
      check("rst_err", err_multi, 0);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      idle_cycles(3);

      // Single request: 3-cycle latency to grant
      req = 5'b00100;
      @(posedge clk); #1;
      check("single_arb_x", arb_x, 5'b00100);
      check("single_g0", grant, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("single_g2", grant, 0);
      @(posedge clk); #1;
      check("single_g3", grant, 5'b00100);
      repeat (4) @(negedge clk);
      done = 5'b00100; req = '0;
      @(posedge clk); #1;
      check("single_rel_g", grant, 0);
      check("single_rel_x", arb_x, 0);
      @(negedge clk);
      done = '0;
      idle_cycles(6);

      // Contention: all five at once, X4 wins first
      req = 5'b11111;
      for (int k = 0; k < 5; k++) begin
         exp = 5'b10000 >> k;
         wait_grant(exp, "cont_wait");
         check("cont_grant", grant, exp);
         repeat (5) @(negedge clk);
         done = exp; req = req & ~exp;
         @(negedge clk);
         done = '0;
      end
      idle_cycles(6);

      // Withdraw while another client holds the grant
      req = 5'b01000;
      wait_grant(5'b01000, "wd_wait");
      @(negedge clk); req[1] = 1'b1;
      @(negedge clk); req[1] = 1'b0;
      saw_g1 = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         saw_g1 |= grant[1];
      end
      check("wd_no_grant", saw_g1, 0);
      check("wd_arb_x1", arb_x[1], 0);
      @(negedge clk);
      done = 5'b01000; req = '0;
      @(negedge clk);
      done = '0;
      idle_cycles(6);

      // Timeout after HOLD cycles with no done
      req = 5'b00001;
      wait_grant(5'b00001, "to_wait");
      cnt = 0;
      while (cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
         if (!grant[0]) break;
      end
      check("to_cycles", cnt, HOLD);
      check("to_pulse", timeout, 1);
      @(negedge clk);
      req = '0;
      idle_cycles(6);

      // Reset mid-grant, then re-request
      req = 5'b00010;
      wait_grant(5'b00010, "rm_wait");
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rm_grant", grant, 0);
      check("rm_arb_x", arb_x, 0);
      check("rm_timeout", timeout, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_grant(5'b00010, "rm_regrant");
      @(negedge clk);
      done = 5'b00010; req = '0;
      @(negedge clk);
      done = '0;
      idle_cycles(6);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < 5; i++) begin
            if (!req[i]) req[i] = ($urandom_range(0, 5) == 0);
            else         req[i] = ($urandom_range(0, 39) != 0);
            done[i] = ($urandom_range(0, 9) == 0);
         end
      end
      @(negedge clk);
      req = '0; done = '0;
      idle_cycles(10);

      // Multi-hot arbiter output sets the sticky error flag
      fault_val = 5'b00011;
      fault_en  = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("err_early", err_multi, 0);
      @(posedge clk); #1;
      check("err_set", err_multi, 1);
      @(negedge clk);
      fault_en = 1'b0;
      idle_cycles(20);
      check("err_sticky", err_multi, 1);
      rst_n = 1'b0;
      #1;
      check("err_cleared", err_multi, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(3);

      // HOLD_MAX = 0: grant never times out
      req_b = 5'b00001;
      cnt = 0;
      while (!grant_b[0] && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("nohold_wait", grant_b, 5'b00001);
      drops = 0;
      repeat (1000) begin
         @(posedge clk); #1;
         if (!grant_b[0] || timeout_b) drops++;
      end
      check("nohold_drops", drops, 0);
      check("nohold_grant", grant_b, 5'b00001);
      @(negedge clk);
      req_b = '0;
      idle_cycles(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
